uart_tx: RTL

//  UART serializer, paired with the receive path on the shared baud-tick generator.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx.sv | 129 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the tx and rx paths: state encoding, frame levels
// and the parity helper.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;
  localparam int MIN_DATA_BITS = 5;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serializer: one word per valid/ready handshake, shifted out LSB first as
// start, data, optional parity and stop bits, paced by an external 1x baud tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 i_clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_b_tick,
  output logic                 o_tx_br_rst,
  output logic                 o_tx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int                CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = (STOP_BITS == 2);
  localparam logic              ODD       = (PARITY_ODD != 0);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 done;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done       = 1'b0;
    unique case (state_q)
      // Ticks are ignored here, so a tick coinciding with the handshake never shortens the start bit.
      IDLE: begin
        if (i_valid) begin
          state_d = START;
          shift_d = i_data;
          par_d   = parity(MAX_DATA_BITS'(i_data), ODD);
          tx_d    = START_BIT;
        end
      end
      START: begin
        if (i_b_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (i_b_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              tx_d       = STOP_BIT;
            end
          end else begin
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (i_b_tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = STOP_BIT;
        end
      end
      STOP: begin
        if (i_b_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
          tx_d = STOP_BIT;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= STOP_BIT;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
    end
  end

  // Holding the baud counter in reset while idle makes every frame start bit-aligned.
  assign o_ready     = (state_q == IDLE);
  assign o_tx_br_rst = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_tx        = tx_q;
  assign o_done      = done;

endmodule
